// File: rtl/keypad_scan_if.sv
// Keypad matrix and key-event signals between keypad_scan (master) and its
// consumer / the physical matrix (slave).
interface keypad_scan_if;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic [3:0] key;
    logic       key_valid;
    logic       key_down;

    modport master (input row_n, output col_n, output key, output key_valid, output key_down);
    modport slave  (output row_n, input col_n, input key, input key_valid, input key_down);
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with press/release debounce and one-cycle key_valid.
// Optional auto-repeat while a key is held: define KEYPAD_REPEAT_EN.
module keypad_scan #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 40
) (
    input  logic          clk,
    input  logic          rst,
    keypad_scan_if.master kp
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_SCANS - 1);

    if (SCAN_DIV < 2) begin : g_bad_div
        $error("keypad_scan: SCAN_DIV must be >= 2");
    end
    if (DEBOUNCE_SCANS < 1) begin : g_bad_db
        $error("keypad_scan: DEBOUNCE_SCANS must be >= 1");
    end
    if (REPEAT_SCANS < 1) begin : g_bad_rep
        $error("keypad_scan: REPEAT_SCANS must be >= 1");
    end

    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_t;

    state_t        state;
    logic [SW-1:0] slot_cnt;
    logic [DW-1:0] db_cnt;
    logic [1:0]    col_idx;
    logic [1:0]    cand_row;
    logic [1:0]    cand_col;
    logic [3:0]    key_q;
    logic          key_valid_q;
    logic          key_down_q;
    logic          row_hit;
    logic [1:0]    act_row;
    logic          sample;
    logic          cand_up;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_SCANS + 1);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_SCANS - 1);
    logic [RW-1:0] rep_cnt;
`endif

    // Lowest-indexed low row wins; scanning downward lets the lowest overwrite.
    always_comb begin
        row_hit = 1'b0;
        act_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!kp.row_n[i]) begin
                row_hit = 1'b1;
                act_row = 2'(i);
            end
        end
    end

    assign sample  = (slot_cnt == SLOT_LAST);
    assign cand_up = kp.row_n[cand_row];

    assign kp.col_n     = ~(4'b0001 << col_idx);
    assign kp.key       = key_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_down  = key_down_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= SCAN;
            slot_cnt    <= '0;
            db_cnt      <= '0;
            col_idx     <= 2'd0;
            cand_row    <= 2'd0;
            cand_col    <= 2'd0;
            key_q       <= 4'h0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt     <= '0;
`endif
        end else begin
            key_valid_q <= 1'b0;
            slot_cnt    <= sample ? '0 : slot_cnt + 1'b1;
            if (sample) begin
                case (state)
                    SCAN: begin
                        if (row_hit) begin
                            cand_row <= act_row;
                            cand_col <= col_idx;
                            db_cnt   <= DW'(1);
                            if (DEBOUNCE_SCANS == 1) begin
                                key_q       <= {act_row, col_idx};
                                key_valid_q <= 1'b1;
                                key_down_q  <= 1'b1;
                                state       <= HELD;
`ifdef KEYPAD_REPEAT_EN
                                rep_cnt     <= '0;
`endif
                            end else begin
                                state <= PRESS_DB;
                            end
                        end else begin
                            col_idx <= col_idx + 2'd1;
                        end
                    end
                    PRESS_DB: begin
                        if (row_hit && act_row == cand_row) begin
                            if (db_cnt == DB_LAST) begin
                                key_q       <= {cand_row, cand_col};
                                key_valid_q <= 1'b1;
                                key_down_q  <= 1'b1;
                                state       <= HELD;
`ifdef KEYPAD_REPEAT_EN
                                rep_cnt     <= '0;
`endif
                            end else begin
                                db_cnt <= db_cnt + DW'(1);
                            end
                        end else begin
                            state   <= SCAN;
                            col_idx <= col_idx + 2'd1;
                        end
                    end
                    HELD: begin
                        if (cand_up) begin
                            db_cnt <= DW'(1);
                            if (DEBOUNCE_SCANS == 1) begin
                                key_down_q <= 1'b0;
                                col_idx    <= col_idx + 2'd1;
                                state      <= SCAN;
                            end else begin
                                state <= REL_DB;
                            end
                        end
`ifdef KEYPAD_REPEAT_EN
                        // Repeat only counts samples where the key is still seen down.
                        else if (rep_cnt == REP_LAST) begin
                            rep_cnt     <= '0;
                            key_valid_q <= 1'b1;
                        end else begin
                            rep_cnt <= rep_cnt + RW'(1);
                        end
`endif
                    end
                    REL_DB: begin
                        if (cand_up) begin
                            if (db_cnt == DB_LAST) begin
                                key_down_q <= 1'b0;
                                col_idx    <= col_idx + 2'd1;
                                state      <= SCAN;
                            end else begin
                                db_cnt <= db_cnt + DW'(1);
                            end
                        end else begin
                            state <= HELD;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end
endmodule
